// File: rtl/generic_bus_mem_slave.sv
// generic_bus_mem_slave
// Terminal memory model for the generic bus (peripheral side). Byte-addressed,
// word-wide storage with configurable first-access and per-beat wait states,
// hint-driven INCR/WRAP bursts sequenced internally, and error responses for
// illegal accesses. rdata/error are only meaningful in the completion cycle.
module generic_bus_mem_slave #(
    parameter int          ADDR_WIDTH       = 32,
    parameter int          DATA_WIDTH       = 32,
    parameter int          MEM_BYTE_WIDTH   = 14,
    parameter int          WAIT_STATES      = 2,
    parameter int          BEAT_WAIT_STATES = 0,
    parameter logic [31:0] ERR_DATA         = 32'hBAD1_BAD1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wen,
    input  logic                    ren,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strobe,
    input  logic                    is_burst,
    input  logic [1:0]              burst_type,
    input  logic [7:0]              burst_length,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    error,
    output logic                    request_stall
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int SH     = $clog2(BYTES);
    localparam int MW     = MEM_BYTE_WIDTH;
    localparam int WORD_W = MW - SH;
    localparam int DEPTH  = 1 << WORD_W;
    localparam int EXT_W  = MW + 10;

    localparam logic [3:0] WS   = 4'(WAIT_STATES);
    localparam logic [3:0] BWS  = 4'(BEAT_WAIT_STATES);
    localparam logic [1:0] INCR = 2'd0;
    localparam logic [1:0] WRAP = 2'd1;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [7:0]      beat_cnt;
    logic [MW-1:0]   beat_addr;
    logic            lat_burst;
    logic [1:0]      lat_type;
    logic [7:0]      lat_len;
    logic            lat_err;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  request;
    logic                  start_err;
    logic                  cur_err;
    logic                  cur_burst;
    logic [1:0]            cur_type;
    logic [7:0]            cur_len;
    logic [7:0]            cur_beat;
    logic [3:0]            cur_cnt;
    logic [3:0]            stall_target;
    logic                  complete;
    logic                  last_beat;
    logic [MW-1:0]         cur_addr;
    logic [MW-1:0]         incr_addr;
    logic [MW-1:0]         wrap_mask;
    logic [MW-1:0]         next_addr;
    logic [WORD_W-1:0]     word_idx;
    logic [DATA_WIDTH-1:0] err_word;
    logic [8:0]            beats;
    logic [EXT_W-1:0]      incr_end;

    // Legality of a transaction as presented on its first cycle
    always_comb begin
        beats     = {1'b0, burst_length} + 9'd1;
        incr_end  = EXT_W'(addr[MW-1:0]) + (EXT_W'(beats) << SH);
        start_err = (ren && wen)
                 || ((addr >> MW) != '0)
                 || ((addr & ADDR_WIDTH'(BYTES - 1)) != '0)
                 || (is_burst && burst_type[1])
                 || (is_burst && burst_type == WRAP && (beats & {1'b0, burst_length}) != 9'd0)
                 || (is_burst && burst_type == INCR && incr_end > (EXT_W'(1) << MW));
    end

    // Current-beat view: live inputs in IDLE, latched context afterwards
    // NOTE: every output of this block is assigned on every path, so no latches are inferred.
    always_comb begin
        request = (ren || wen) && !reset;
        if (state == IDLE) begin
            cur_addr  = addr[MW-1:0];
            cur_burst = is_burst;
            cur_type  = burst_type;
            cur_len   = burst_length;
            cur_beat  = '0;
            cur_cnt   = '0;
            cur_err   = start_err;
        end else begin
            cur_addr  = beat_addr;
            cur_burst = lat_burst;
            cur_type  = lat_type;
            cur_len   = lat_len;
            cur_beat  = beat_cnt;
            cur_cnt   = wait_cnt;
            cur_err   = (ren && wen) || (state == WAIT && lat_err);
        end

        stall_target  = (state == BEAT) ? BWS : WS;
        request_stall = request && (cur_cnt != stall_target);
        complete      = request && !request_stall;
        last_beat     = !cur_burst || (cur_beat == cur_len) || cur_err;

        // WRAP keeps the high bits and increments only inside the aligned block
        wrap_mask = MW'((EXT_W'({1'b0, cur_len} + 9'd1) << SH) - EXT_W'(1));
        incr_addr = cur_addr + MW'(BYTES);
        next_addr = (cur_type == WRAP) ? ((cur_addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
        word_idx  = WORD_W'(cur_addr >> SH);

        for (int b = 0; b < BYTES; b++) begin
            err_word[b*8 +: 8] = ERR_DATA[(b % 4)*8 +: 8];
        end

        error = complete && cur_err;
        if (complete && cur_err) begin
            rdata = err_word;
        end else if (complete && ren) begin
            rdata = mem[word_idx];
        end else begin
            rdata = '0;
        end
    end

    // Transaction sequencer: wait-state counting, beat counting, address stepping
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            beat_cnt  <= '0;
            beat_addr <= '0;
            lat_burst <= 1'b0;
            lat_type  <= '0;
            lat_len   <= '0;
            lat_err   <= 1'b0;
        end else begin
            if (state == IDLE && request) begin
                lat_burst <= is_burst;
                lat_type  <= burst_type;
                lat_len   <= burst_length;
                lat_err   <= start_err;
                beat_addr <= addr[MW-1:0];
            end
            if (!request) begin
                state    <= IDLE;
                wait_cnt <= '0;
                beat_cnt <= '0;
            end else if (complete) begin
                wait_cnt <= '0;
                if (last_beat) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else begin
                    state     <= BEAT;
                    beat_cnt  <= cur_beat + 8'd1;
                    beat_addr <= next_addr;
                end
            end else begin
                wait_cnt <= cur_cnt + 4'd1;
                if (state == IDLE) begin
                    state <= WAIT;
                end
            end
        end
    end

    // Byte-lane write on a legal write completion
    // NOTE: the storage array is deliberately not reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (complete && wen && !cur_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_generic_bus_mem_slave.sv
// Directed self-checking bench for generic_bus_mem_slave
// (WAIT_STATES=2, BEAT_WAIT_STATES=1, 32-bit data, 16 KB memory).
module tb_generic_bus_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        is_burst;
    logic [1:0]  burst_type;
    logic [7:0]  burst_length;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd_v  [4];
    logic [31:0] exp_v [4];
    int          cyc_v [4];

    generic_bus_mem_slave #(
        .WAIT_STATES      (2),
        .BEAT_WAIT_STATES (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wen           (wen),
        .ren           (ren),
        .addr          (addr),
        .wdata         (wdata),
        .strobe        (strobe),
        .is_burst      (is_burst),
        .burst_type    (burst_type),
        .burst_length  (burst_length),
        .rdata         (rdata),
        .error         (error),
        .request_stall (request_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        wen      = 1'b0;
        ren      = 1'b0;
        is_burst = 1'b0;
    endtask

    // Drive one transaction starting now (just after a rising edge) and check each completion
    task automatic txn(input string tag, input logic w, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic b, input logic [1:0] bt,
                       input logic [7:0] bl, input int nbeats, input logic exp_err);
        int beat = 0;
        int cyc  = 0;
        wen = w; ren = r; addr = a; strobe = s;
        is_burst = b; burst_type = bt; burst_length = bl;
        wdata = wd_v[0];
        while (beat < nbeats && cyc < 64) begin
            @(negedge clk);
            if (!request_stall) begin
                check($sformatf("%s b%0d cyc", tag, beat), 64'(cyc), 64'(cyc_v[beat]));
                check($sformatf("%s b%0d rdata", tag, beat), 64'(rdata), 64'(exp_v[beat]));
                check($sformatf("%s b%0d err", tag, beat), 64'(error), 64'(exp_err));
                beat++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (beat < nbeats) wdata = wd_v[beat];
        end
        if (beat < nbeats) check({tag, " timeout"}, 64'(beat), 64'(nbeats));
        idle_bus();
    endtask

    task automatic single(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
        wd_v[0] = d; exp_v[0] = exp_rd; cyc_v[0] = 2;
        txn(tag, w, !w, a, s, 1'b0, 2'd0, 8'd0, 1, 1'b0);
    endtask

    task automatic burst4(input string tag, input logic w, input logic [31:0] a, input logic [1:0] bt,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
        wd_v[0] = d0; wd_v[1] = d1; wd_v[2] = d2; wd_v[3] = d3;
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = w ? 32'h0 : wd_v[i];
            cyc_v[i] = 2 + 2 * i;
        end
        txn(tag, w, !w, a, 4'hF, 1'b1, bt, 8'd3, 4, 1'b0);
    endtask

    task automatic err_case(input string tag, input logic w, input logic r, input logic [31:0] a,
                            input logic b, input logic [1:0] bt, input logic [7:0] bl);
        wd_v[0] = 32'h0; exp_v[0] = 32'hBAD1_BAD1; cyc_v[0] = 2;
        txn(tag, w, r, a, 4'hF, b, bt, bl, 1, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        addr = '0; wdata = '0; strobe = '0; burst_type = '0; burst_length = '0;
        repeat (2) @(posedge clk);
        #1 ren = 1'b1;
        @(negedge clk);
        check("reset stall", 64'(request_stall), 64'(0));
        check("reset rdata", 64'(rdata), 64'(0));
        check("reset err", 64'(error), 64'(0));
        @(posedge clk);
        #1 ren = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single accesses and strobed partial write
        single("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
        single("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
        single("wr20", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0);
        single("wr20s", 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'h0);
        single("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hFF22_FF44);

        // INCR write then INCR read back
        burst4("incr_wr", 1'b1, 32'h100, 2'd0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
        burst4("incr_rd", 1'b0, 32'h100, 2'd0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);

        // WRAP write from 0x108 lands at 108,10C,100,104; INCR read from 0x100 sees B2,B3,B0,B1
        burst4("wrap_wr", 1'b1, 32'h108, 2'd1, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
        burst4("wrap_chk", 1'b0, 32'h100, 2'd0, 32'hB000_0002, 32'hB000_0003, 32'hB000_0000, 32'hB000_0001);
        burst4("wrap_rd", 1'b0, 32'h108, 2'd1, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);

        // Error responses
        err_case("e_range", 1'b0, 1'b1, 32'h4000, 1'b0, 2'd0, 8'd0);
        err_case("e_align", 1'b0, 1'b1, 32'h2, 1'b0, 2'd0, 8'd0);
        err_case("e_rw", 1'b1, 1'b1, 32'h10, 1'b0, 2'd0, 8'd0);
        err_case("e_type", 1'b0, 1'b1, 32'h10, 1'b1, 2'd2, 8'd0);
        err_case("e_wrap3", 1'b0, 1'b1, 32'h100, 1'b1, 2'd1, 8'd2);
        err_case("e_cross", 1'b0, 1'b1, 32'h3FF8, 1'b1, 2'd0, 8'd3);
        err_case("e_wrrange", 1'b1, 1'b0, 32'h4010, 1'b0, 2'd0, 8'd0);
        single("rd10_keep", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
        single("rd10_wrap", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);

        // Aborted write: wen dropped in cycle 1
        wen = 1'b1; addr = 32'h10; wdata = 32'h5555_5555; strobe = 4'hF;
        @(negedge clk);
        check("abort stall0", 64'(request_stall), 64'(1));
        @(posedge clk);
        #1 wen = 1'b0;
        @(negedge clk);
        check("abort stall1", 64'(request_stall), 64'(0));
        @(posedge clk);
        #1;
        single("rd_abort", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);

        // Reset during beat 2 of a 4-beat INCR write over zeroed words
        burst4("zero_wr", 1'b1, 32'h200, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        wen = 1'b1; addr = 32'h200; strobe = 4'hF; is_burst = 1'b1;
        burst_type = 2'd0; burst_length = 8'd3; wdata = 32'hC000_0000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) wdata = 32'hC000_0001;
            if (c == 4) wdata = 32'hC000_0002;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid stall", 64'(request_stall), 64'(0));
        check("rst_mid rdata", 64'(rdata), 64'(0));
        check("rst_mid err", 64'(error), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        idle_bus();
        @(posedge clk);
        #1;
        burst4("rst_rd", 1'b0, 32'h200, 2'd0, 32'hC000_0000, 32'hC000_0001, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
